// File: rtl/rtmc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rtmc_regfile
// Description : Control/status register file on the SPI slave's register bus.
//               Provides RW control registers with per-register write strobes,
//               sampled RO status inputs, and a sticky, maskable W1C event
//               register that drives an interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   reg_addr/reg_wdat   : access address / write data, sampled with strobes
//   reg_wr/reg_rd       : one-cycle write / read strobes
//   reg_rdat            : read data, valid with reg_ack, held between reads
//   reg_ack/reg_err     : one-cycle acknowledge, error flag for failed access
//   rw_q/wr_stb         : RW register contents (flattened), write pulses
//   ro_d                : RO register values (flattened), sampled at read
//   evt_in/evt_q        : event set pulses / sticky event register
//   irq                 : |(evt_q & mask)
// Address map: 0x00..NUM_RW-1 RW, 0x40.. RO, 0x7E MASK, 0x7F EVT (W1C)
// ============================================================================
module rtmc_regfile #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int NUM_RW = 16,
  parameter int NUM_RO = 4,
  parameter logic [NUM_RW*DATA_W-1:0] RW_RESET = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_W-1:0]                     reg_addr,
  input  logic [DATA_W-1:0]                     reg_wdat,
  input  logic                                  reg_wr,
  input  logic                                  reg_rd,
  output logic [DATA_W-1:0]                     reg_rdat,
  output logic                                  reg_ack,
  output logic                                  reg_err,
  output logic [NUM_RW*DATA_W-1:0]              rw_q,
  output logic [NUM_RW-1:0]                     wr_stb,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_W-1:0] ro_d,
  input  logic [DATA_W-1:0]                     evt_in,
  output logic [DATA_W-1:0]                     evt_q,
  output logic                                  irq
);

  localparam logic [ADDR_W-1:0] c_ro_base   = ADDR_W'('h40);
  localparam logic [ADDR_W-1:0] c_mask_addr = ADDR_W'('h7E);
  localparam logic [ADDR_W-1:0] c_evt_addr  = ADDR_W'('h7F);

  logic [DATA_W-1:0] r_rw [NUM_RW];
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_evt;
  logic [DATA_W-1:0] r_rdat;
  logic              r_ack;
  logic              r_err;
  logic [NUM_RW-1:0] r_wr_stb;

  logic [NUM_RW-1:0] w_rw_hit;
  logic              w_ro_hit;
  logic              w_mask_hit;
  logic              w_evt_hit;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_wr_only;
  logic              w_rd_only;
  logic              w_wr_mapped;
  logic              w_rd_mapped;
  logic [DATA_W-1:0] w_evt_clr;

  // Address decode and read-value mux. Upper address bits take part in every
  // compare, so anything at or above 0x80 falls through as unmapped.
  always_comb begin
    w_rw_hit = '0;
    w_ro_hit = 1'b0;
    w_rd_val = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (reg_addr == ADDR_W'(i)) begin
        w_rw_hit[i] = 1'b1;
        w_rd_val    = r_rw[i];
      end
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (reg_addr == c_ro_base + ADDR_W'(i)) begin
        w_ro_hit = 1'b1;
        w_rd_val = ro_d[i*DATA_W +: DATA_W];
      end
    end
    w_mask_hit = (reg_addr == c_mask_addr);
    w_evt_hit  = (reg_addr == c_evt_addr);
    if (w_mask_hit) w_rd_val = r_mask;
    // EVT reads return the pre-update value: r_evt is the flop output.
    if (w_evt_hit)  w_rd_val = r_evt;
  end

  // Simultaneous wr+rd is a protocol error: neither side is performed.
  assign w_wr_only   = reg_wr & ~reg_rd;
  assign w_rd_only   = reg_rd & ~reg_wr;
  assign w_wr_mapped = (|w_rw_hit) | w_mask_hit | w_evt_hit;
  assign w_rd_mapped = (|w_rw_hit) | w_ro_hit | w_mask_hit | w_evt_hit;
  assign w_evt_clr   = (w_wr_only && w_evt_hit) ? reg_wdat : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RW; i++) begin
        r_rw[i] <= RW_RESET[i*DATA_W +: DATA_W];
      end
      r_mask   <= '0;
      r_evt    <= '0;
      r_rdat   <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_wr_stb <= '0;
    end else begin
      r_ack    <= reg_wr | reg_rd;
      r_err    <= 1'b0;
      r_wr_stb <= '0;
      // Set is OR-ed in after the clear, so a coincident set wins.
      r_evt    <= (r_evt & ~w_evt_clr) | evt_in;

      if (reg_wr && reg_rd) begin
        r_err  <= 1'b1;
        r_rdat <= '0;
      end else if (w_wr_only) begin
        if (w_wr_mapped) begin
          for (int i = 0; i < NUM_RW; i++) begin
            if (w_rw_hit[i]) begin
              r_rw[i]     <= reg_wdat;
              r_wr_stb[i] <= 1'b1;
            end
          end
          if (w_mask_hit) r_mask <= reg_wdat;
        end else begin
          r_err <= 1'b1;
        end
      end else if (w_rd_only) begin
        if (w_rd_mapped) begin
          r_rdat <= w_rd_val;
        end else begin
          r_rdat <= '0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
      assign rw_q[g*DATA_W +: DATA_W] = r_rw[g];
    end
  endgenerate

  assign reg_rdat = r_rdat;
  assign reg_ack  = r_ack;
  assign reg_err  = r_err;
  assign wr_stb   = r_wr_stb;
  assign evt_q    = r_evt;
  assign irq      = |(r_evt & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_rtmc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtmc_regfile
// Description : Directed self-checking bench for rtmc_regfile (default
//               geometry: 16 RW, 4 RO, 16-bit data, 7-bit address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtmc_regfile;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int NUM_RW = 16;
  localparam int NUM_RO = 4;
  localparam logic [NUM_RW*DATA_W-1:0] RW_RESET = {{14{16'h0000}}, 16'h1234, 16'h00A5};

  logic                       clk;
  logic                       rst_n;
  logic [ADDR_W-1:0]          reg_addr;
  logic [DATA_W-1:0]          reg_wdat;
  logic                       reg_wr;
  logic                       reg_rd;
  logic [DATA_W-1:0]          reg_rdat;
  logic                       reg_ack;
  logic                       reg_err;
  logic [NUM_RW*DATA_W-1:0]   rw_q;
  logic [NUM_RW-1:0]          wr_stb;
  logic [NUM_RO*DATA_W-1:0]   ro_d;
  logic [DATA_W-1:0]          evt_in;
  logic [DATA_W-1:0]          evt_q;
  logic                       irq;

  int n_checks;
  int n_fails;
  logic [NUM_RW*DATA_W-1:0] exp_rw;

  rtmc_regfile #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_RW  (NUM_RW),
    .NUM_RO  (NUM_RO),
    .RW_RESET(RW_RESET)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .reg_addr(reg_addr),
    .reg_wdat(reg_wdat),
    .reg_wr  (reg_wr),
    .reg_rd  (reg_rd),
    .reg_rdat(reg_rdat),
    .reg_ack (reg_ack),
    .reg_err (reg_err),
    .rw_q    (rw_q),
    .wr_stb  (wr_stb),
    .ro_d    (ro_d),
    .evt_in  (evt_in),
    .evt_q   (evt_q),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    reg_wr   = wr;
    reg_rd   = rd;
    reg_addr = a;
    reg_wdat = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_rw   = RW_RESET;
    rst_n    = 1'b0;
    idle();
    ro_d     = {16'h0000, 16'h5A5A, 16'h1111, 16'h2222};
    evt_in   = 16'hFFFF;   // must be ignored while in reset

    // ---- reset state ----
    tick();
    tick();
    rst_n  = 1'b1;
    evt_in = '0;
    chk("rst_rw_q",  rw_q, exp_rw);
    chk("rst_reg1",  rw_q[31:16], 16'h1234);
    chk("rst_rdat",  reg_rdat, 0);
    chk("rst_ack",   reg_ack, 0);
    chk("rst_err",   reg_err, 0);
    chk("rst_wrstb", wr_stb, 0);
    chk("rst_evt",   evt_q, 0);
    chk("rst_irq",   irq, 0);

    // ---- write 0x03 then read back on the very next cycle ----
    drive(1'b1, 1'b0, 7'h03, 16'hBEEF);
    tick();
    drive(1'b0, 1'b1, 7'h03, 16'h0000);
    exp_rw[3*16 +: 16] = 16'hBEEF;
    chk("wr3_ack",   reg_ack, 1);
    chk("wr3_err",   reg_err, 0);
    chk("wr3_stb",   wr_stb, 16'h0008);
    chk("wr3_rw_q",  rw_q, exp_rw);
    tick();
    idle();
    chk("rd3_ack",   reg_ack, 1);
    chk("rd3_rdat",  reg_rdat, 16'hBEEF);
    chk("rd3_stb",   wr_stb, 0);

    // ---- last RW register 0x0F, first address past RW 0x10 ----
    drive(1'b1, 1'b0, 7'h0F, 16'h7777);
    tick();
    drive(1'b1, 1'b0, 7'h10, 16'h9999);
    exp_rw[15*16 +: 16] = 16'h7777;
    chk("wr15_stb",  wr_stb, 16'h8000);
    chk("wr15_err",  reg_err, 0);
    tick();
    idle();
    chk("wr16_err",  reg_err, 1);
    chk("wr16_ack",  reg_ack, 1);
    chk("wr16_stb",  wr_stb, 0);
    chk("wr16_rw_q", rw_q, exp_rw);

    // ---- RO range ----
    drive(1'b0, 1'b1, 7'h42, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 7'h42, 16'hFFFF);
    chk("ro2_rdat",  reg_rdat, 16'h5A5A);
    chk("ro2_err",   reg_err, 0);
    tick();
    drive(1'b0, 1'b1, 7'h20, 16'h0000);
    chk("wro_ack",   reg_ack, 1);
    chk("wro_err",   reg_err, 1);
    chk("wro_stb",   wr_stb, 0);
    chk("wro_rdat",  reg_rdat, 16'h5A5A);   // rdat holds across writes
    chk("wro_rw_q",  rw_q, exp_rw);
    tick();
    drive(1'b0, 1'b1, 7'h44, 16'h0000);
    chk("un20_rdat", reg_rdat, 0);
    chk("un20_err",  reg_err, 1);
    tick();
    drive(1'b0, 1'b1, 7'h43, 16'h0000);
    chk("un44_err",  reg_err, 1);
    tick();
    idle();
    chk("ro3_rdat",  reg_rdat, 16'h0000);
    chk("ro3_err",   reg_err, 0);

    // ---- event register / irq ----
    evt_in = 16'h0005;
    tick();
    evt_in = '0;
    chk("evt_set",   evt_q, 16'h0005);
    chk("evt_irq0",  irq, 0);
    drive(1'b1, 1'b0, 7'h7E, 16'h0004);
    tick();
    drive(1'b0, 1'b1, 7'h7E, 16'h0000);
    chk("mask_irq",  irq, 1);
    tick();
    drive(1'b1, 1'b0, 7'h7F, 16'h0004);
    evt_in = 16'h0004;
    chk("mask_rd",   reg_rdat, 16'h0004);
    tick();
    evt_in = '0;
    drive(1'b1, 1'b0, 7'h7F, 16'h0004);
    chk("setwins",   evt_q, 16'h0005);
    chk("setw_irq",  irq, 1);
    tick();
    drive(1'b0, 1'b1, 7'h7F, 16'h0000);
    evt_in = 16'h0002;
    chk("w1c_evt",   evt_q, 16'h0001);
    chk("w1c_irq",   irq, 0);
    tick();
    idle();
    evt_in = '0;
    chk("evt_rdold", reg_rdat, 16'h0001);
    chk("evt_new",   evt_q, 16'h0003);

    // ---- wr and rd together ----
    drive(1'b1, 1'b1, 7'h03, 16'h1111);
    tick();
    idle();
    chk("both_ack",  reg_ack, 1);
    chk("both_err",  reg_err, 1);
    chk("both_rdat", reg_rdat, 0);
    chk("both_stb",  wr_stb, 0);
    tick();
    chk("both_1ack", reg_ack, 0);
    chk("both_rw_q", rw_q, exp_rw);

    // ---- back-to-back reads of 0x00..0x02 ----
    drive(1'b1, 1'b0, 7'h02, 16'hC0DE);
    tick();
    drive(1'b0, 1'b1, 7'h00, 16'h0000);
    tick();
    drive(1'b0, 1'b1, 7'h01, 16'h0000);
    chk("b2b0_rdat", reg_rdat, 16'h00A5);
    chk("b2b0_ack",  reg_ack, 1);
    tick();
    drive(1'b0, 1'b1, 7'h02, 16'h0000);
    chk("b2b1_rdat", reg_rdat, 16'h1234);
    chk("b2b1_ack",  reg_ack, 1);
    tick();
    idle();
    chk("b2b2_rdat", reg_rdat, 16'hC0DE);
    chk("b2b2_ack",  reg_ack, 1);
    tick();
    chk("b2b_end",   reg_ack, 0);

    // ---- reset coinciding with a strobe ----
    evt_in = 16'h0010;
    tick();
    evt_in = '0;
    drive(1'b1, 1'b0, 7'h05, 16'h5555);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    chk("mrst_ack",  reg_ack, 0);
    chk("mrst_rw_q", rw_q, RW_RESET);
    chk("mrst_evt",  evt_q, 0);
    chk("mrst_stb",  wr_stb, 0);
    chk("mrst_rdat", reg_rdat, 0);
    tick();
    drive(1'b0, 1'b1, 7'h7E, 16'h0000);
    chk("mrst_noack", reg_ack, 0);
    tick();
    idle();
    chk("mrst_mask", reg_rdat, 0);
    chk("mrst_irq",  irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
